// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR packet arbiter: FSM encoding, tap count and
// flush-counter sizing.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPass,
    StFlush
  } state_e;

  localparam int unsigned FIR_NUM_COEFFS    = 15;
  localparam int unsigned FLUSH_LEN_DEFAULT = FIR_NUM_COEFFS - 1;

  // Counter must hold 0..flush_len-1 and never collapse to zero width.
  function automatic int unsigned cnt_width(input int unsigned flush_len);
    int unsigned w;
    w = $clog2(flush_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker: a lone request wins outright, a tie goes to the source
// that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/fir_packet_arbiter.sv
// Shares one FIR AXI-Stream input between two packet sources; each granted packet is
// forwarded whole, then followed by FLUSH_LEN zero beats that drain the filter delay line.
module fir_packet_arbiter
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FLUSH_LEN          = FLUSH_LEN_DEFAULT
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_areset,
  input  logic                            s00_axis_tvalid,
  input  logic                            s00_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  output logic                            s00_axis_tready,
  input  logic                            s01_axis_tvalid,
  input  logic                            s01_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  output logic                            s01_axis_tready,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tvalid,
  output logic                            m00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tuser,
  output logic                            grant_id,
  output logic                            busy
);

  localparam int unsigned     CntW    = cnt_width(FLUSH_LEN);
  localparam bit              NoFlush = (FLUSH_LEN == 0);
  localparam logic [CntW-1:0] CntLast = NoFlush ? '0 : CntW'(FLUSH_LEN - 1);

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          grant_q, grant_d;
  logic                          last_grant_q, last_grant_d;
  logic                          m_valid_q, m_valid_d;
  logic                          m_last_q, m_last_d;
  logic                          m_user_q, m_user_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;

  logic                          load_en;
  logic                          src_valid, src_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] src_data;
  logic                          gnt_valid, gnt_id;

  rr_arb2 u_rr_arb2 (
    .req        ({s01_axis_tvalid, s00_axis_tvalid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Output register may only take a new beat when empty or being drained this cycle.
  assign load_en   = !m_valid_q || m00_axis_tready;
  assign src_valid = grant_q ? s01_axis_tvalid : s00_axis_tvalid;
  assign src_last  = grant_q ? s01_axis_tlast  : s00_axis_tlast;
  assign src_data  = grant_q ? s01_axis_tdata  : s00_axis_tdata;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    m_valid_d       = m_valid_q;
    m_last_d        = m_last_q;
    m_user_d        = m_user_q;
    m_data_d        = m_data_q;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    if (load_en) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          grant_d      = gnt_id;
          last_grant_d = gnt_id;
          state_d      = StPass;
        end
      end
      StPass: begin
        s00_axis_tready = load_en && !grant_q;
        s01_axis_tready = load_en &&  grant_q;
        if (load_en && src_valid) begin
          m_valid_d = 1'b1;
          m_data_d  = src_data;
          m_user_d  = grant_q;
          // With a flush tail the packet boundary moves to the last zero beat.
          m_last_d  = NoFlush ? src_last : 1'b0;
          if (src_last) begin
            if (NoFlush) begin
              state_d = StIdle;
            end else begin
              state_d = StFlush;
              cnt_d   = '0;
            end
          end
        end
      end
      StFlush: begin
        if (load_en) begin
          m_valid_d = 1'b1;
          m_data_d  = '0;
          m_user_d  = grant_q;
          m_last_d  = (cnt_q == CntLast);
          cnt_d     = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_user_q     <= m_user_d;
      m_data_q     <= m_data_d;
    end
  end

  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tlast  = m_last_q;
  assign m00_axis_tdata  = m_data_q;
  assign m00_axis_tuser  = m_user_q;
  assign m00_axis_tstrb  = '1;
  assign grant_id        = grant_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_fir_packet_arbiter.sv
// Randomised scoreboard bench for fir_packet_arbiter: per-source expected beat queues
// (data plus flush tail), an output monitor, and a FLUSH_LEN = 0 side instance.
module tb_fir_packet_arbiter;

  localparam int W  = 32;
  localparam int FL = 14;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           s0_valid, s0_last, s0_ready;
  logic [W-1:0]   s0_data;
  logic           s1_valid, s1_last, s1_ready;
  logic [W-1:0]   s1_data;
  logic           m_ready, m_valid, m_last, m_user;
  logic [W-1:0]   m_data;
  logic [W/8-1:0] m_strb;
  logic           grant_id, busy;

  logic           z_s0_valid, z_s0_last, z_s0_ready;
  logic [W-1:0]   z_s0_data;
  logic           z_s1_valid, z_s1_last, z_s1_ready;
  logic [W-1:0]   z_s1_data;
  logic           z_m_ready, z_m_valid, z_m_last, z_m_user;
  logic [W-1:0]   z_m_data;
  logic [W/8-1:0] z_m_strb;
  logic           z_grant_id, z_busy;

  fir_packet_arbiter #(.C_AXIS_TDATA_WIDTH(W), .FLUSH_LEN(FL)) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s0_valid),
    .s00_axis_tlast  (s0_last),
    .s00_axis_tdata  (s0_data),
    .s00_axis_tready (s0_ready),
    .s01_axis_tvalid (s1_valid),
    .s01_axis_tlast  (s1_last),
    .s01_axis_tdata  (s1_data),
    .s01_axis_tready (s1_ready),
    .m00_axis_tready (m_ready),
    .m00_axis_tvalid (m_valid),
    .m00_axis_tlast  (m_last),
    .m00_axis_tdata  (m_data),
    .m00_axis_tstrb  (m_strb),
    .m00_axis_tuser  (m_user),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  fir_packet_arbiter #(.C_AXIS_TDATA_WIDTH(W), .FLUSH_LEN(0)) dut_noflush (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (z_s0_valid),
    .s00_axis_tlast  (z_s0_last),
    .s00_axis_tdata  (z_s0_data),
    .s00_axis_tready (z_s0_ready),
    .s01_axis_tvalid (z_s1_valid),
    .s01_axis_tlast  (z_s1_last),
    .s01_axis_tdata  (z_s1_data),
    .s01_axis_tready (z_s1_ready),
    .m00_axis_tready (z_m_ready),
    .m00_axis_tvalid (z_m_valid),
    .m00_axis_tlast  (z_m_last),
    .m00_axis_tdata  (z_m_data),
    .m00_axis_tstrb  (z_m_strb),
    .m00_axis_tuser  (z_m_user),
    .grant_id        (z_grant_id),
    .busy            (z_busy)
  );

  int    checks   = 0;
  int    failures = 0;
  beat_t expq0[$];
  beat_t expq1[$];
  beat_t zexpq[$];
  int    owners[$];
  int    lens[$];
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int src, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    if (src == 0) expq0.push_back(b);
    else          expq1.push_back(b);
  endtask

  task automatic set_src(input int src, input logic v, input logic l, input logic [W-1:0] d);
    if (src == 0) begin
      s0_valid = v; s0_last = l; s0_data = d;
    end else begin
      s1_valid = v; s1_last = l; s1_data = d;
    end
  endtask

  // Holds the current beat until the source sees ready before an edge; returns at edge+1.
  task automatic wait_accept(input int src);
    logic acc;
    int   guard;
    guard = 0;
    do begin
      @(negedge clk);
      acc = (src == 0) ? s0_ready : s1_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 2000);
    check("src_handshake", acc, 1);
  endtask

  // Reference: a packet of len beats from src leaves as len beats then FL zeros, one tlast.
  task automatic drive_pkt(input int src, input int len, input int base, input int hole_at,
                           input int hole_len, input bit rand_holes);
    logic [W-1:0] d[$];
    for (int i = 0; i < len; i++) begin
      d.push_back((base != 0) ? W'(base + i) : W'($urandom));
      push_exp(src, d[i], (FL == 0) && (i == len - 1));
    end
    for (int i = 0; i < FL; i++) push_exp(src, '0, i == FL - 1);
    for (int i = 0; i < len; i++) begin
      if (i == hole_at) begin
        set_src(src, 1'b0, 1'b0, '0);
        repeat (hole_len) @(posedge clk);
        #1;
      end
      if (rand_holes && ($urandom % 4 == 0)) begin
        set_src(src, 1'b0, 1'b0, '0);
        repeat (1 + $urandom % 2) @(posedge clk);
        #1;
      end
      set_src(src, 1'b1, i == len - 1, d[i]);
      wait_accept(src);
    end
    set_src(src, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(expq0.size() == 0 && expq1.size() == 0 && !busy && !m_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", n < 3000, 1);
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Output monitor: hold-while-stalled, packet atomicity and scoreboard pops.
  bit           in_pkt    = 1'b0;
  int           cur_owner = 0;
  int           cur_len   = 0;
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last, prev_user;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      in_pkt    = 1'b0;
      prev_hold = 1'b0;
      cur_len   = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
        check("hold_user", m_user, prev_user);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      prev_user = m_user;
      if (m_valid && m_ready) begin
        check("tstrb", m_strb, {(W/8){1'b1}});
        if (in_pkt) check("no_interleave", m_user, cur_owner);
        else begin
          in_pkt    = 1'b1;
          cur_owner = int'(m_user);
        end
        cur_len++;
        if ((m_user == 1'b0) ? (expq0.size() == 0) : (expq1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat src=%0d actual=0x%0h required=none", m_user, m_data);
        end else begin
          e = m_user ? expq1.pop_front() : expq0.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
        end
        if (m_last) begin
          owners.push_back(int'(m_user));
          lens.push_back(cur_len);
          in_pkt  = 1'b0;
          cur_len = 0;
        end
      end
    end
  end

  // One idle cycle between back-to-back packets while both sources keep requesting.
  bit   alt_phase = 1'b0;
  bit   armed     = 1'b0;
  int   gap       = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (alt_phase) begin
      if (!busy) gap++;
      else if (!prev_busy) begin
        if (armed) check("idle_gap", gap, 1);
        armed = 1'b1;
        gap   = 0;
      end
      prev_busy = busy;
    end
  end

  bit hole_phase = 1'b0;
  int hole_cnt   = 0;
  always @(negedge clk) begin
    if (hole_phase && busy && !m_valid && grant_id) hole_cnt++;
  end

  int z_beats = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst && z_m_valid && z_m_ready) begin
      z_beats++;
      if (zexpq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL z_unexpected_beat actual=0x%0h required=none", z_m_data);
      end else begin
        e = zexpq.pop_front();
        check("z_beat_data", z_m_data, e.data);
        check("z_beat_last", z_m_last, e.last);
        check("z_beat_user", z_m_user, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t    zb;
    int       cycles;
    logic [W-1:0] d0;
    rst = 1'b1;
    set_src(0, 1'b0, 1'b0, '0);
    set_src(1, 1'b0, 1'b0, '0);
    z_s0_valid = 1'b0; z_s0_last = 1'b0; z_s0_data = '0;
    z_s1_valid = 1'b0; z_s1_last = 1'b0; z_s1_data = '0;
    z_m_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_user", m_user, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_z_m_valid", z_m_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single packet 1,2,3,4 from source 0 with first-beat latency.
    fork
      drive_pkt(0, 4, 1, -1, 0, 1'b0);
      begin
        cycles = 0;
        @(negedge clk);
        while (!m_valid && cycles < 20) begin
          cycles++;
          @(negedge clk);
        end
        check("first_beat_latency", cycles, 2);
      end
    join
    wait_drain();
    check("single_pkt_count", owners.size(), 1);
    if (owners.size() >= 1) begin
      check("single_pkt_owner", owners[0], 0);
      check("single_pkt_len", lens[0], 4 + FL);
    end

    // Both sources saturate: last grant was source 0, so source 1 wins the first tie.
    owners.delete();
    lens.delete();
    alt_phase = 1'b1;
    fork
      repeat (4) drive_pkt(0, 3, 0, -1, 0, 1'b0);
      repeat (4) drive_pkt(1, 3, 0, -1, 0, 1'b0);
    join
    wait_drain();
    alt_phase = 1'b0;
    check("alt_pkt_count", owners.size(), 8);
    if (owners.size() >= 1) check("alt_first_owner", owners[0], 1);
    for (int i = 1; i < owners.size(); i++) check("alternate", owners[i], 1 - owners[i-1]);
    foreach (lens[i]) check("alt_pkt_len", lens[i], 3 + FL);

    // Random backpressure and random source gaps.
    rand_ready = 1'b1;
    fork
      repeat (6) begin
        repeat ($urandom % 4) @(posedge clk);
        #1;
        drive_pkt(0, 1 + int'($urandom % 6), 0, -1, 0, 1'b1);
      end
      repeat (6) begin
        repeat ($urandom % 4) @(posedge clk);
        #1;
        drive_pkt(1, 1 + int'($urandom % 6), 0, -1, 0, 1'b1);
      end
    join
    rand_ready = 1'b0;
    wait_drain();

    // Source 1 stalls three cycles mid-packet; source 0 must wait for the whole tail.
    owners.delete();
    hole_cnt   = 0;
    hole_phase = 1'b1;
    fork
      drive_pkt(1, 5, 0, 2, 3, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_pkt(0, 2, 0, -1, 0, 1'b0);
      end
    join
    wait_drain();
    hole_phase = 1'b0;
    check("hole_gap_cycles", hole_cnt, 4);
    check("hole_pkt_count", owners.size(), 2);
    if (owners.size() >= 2) begin
      check("hole_owner0", owners[0], 1);
      check("hole_owner1", owners[1], 0);
    end

    // Reset after the second beat of a five-beat packet from source 0.
    d0 = W'($urandom);
    push_exp(0, d0, 1'b0);
    set_src(0, 1'b1, 1'b0, d0);
    wait_accept(0);
    set_src(0, 1'b1, 1'b0, W'($urandom));
    wait_accept(0);
    set_src(0, 1'b1, 1'b0, W'($urandom));
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_s0_ready", s0_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_src(0, 1'b0, 1'b0, '0);
    expq0.delete();
    expq1.delete();
    owners.delete();
    @(posedge clk);
    #1;
    fork
      drive_pkt(0, 2, 0, -1, 0, 1'b0);
      drive_pkt(1, 2, 0, -1, 0, 1'b0);
    join
    wait_drain();
    check("postrst_pkt_count", owners.size(), 2);
    if (owners.size() >= 2) begin
      check("postrst_tie_owner0", owners[0], 0);
      check("postrst_tie_owner1", owners[1], 1);
    end

    // FLUSH_LEN = 0: packet 7, 8 passes through with no zero tail.
    zb.data = W'(7); zb.last = 1'b0; zexpq.push_back(zb);
    zb.data = W'(8); zb.last = 1'b1; zexpq.push_back(zb);
    z_s0_valid = 1'b1; z_s0_last = 1'b0; z_s0_data = W'(7);
    cycles = 0;
    do begin
      @(negedge clk);
      zb.last = z_s0_ready;
      @(posedge clk);
      #1;
      cycles++;
    end while (!zb.last && cycles < 50);
    z_s0_last = 1'b1; z_s0_data = W'(8);
    do begin
      @(negedge clk);
      zb.last = z_s0_ready;
      @(posedge clk);
      #1;
      cycles++;
    end while (!zb.last && cycles < 50);
    z_s0_valid = 1'b0; z_s0_last = 1'b0; z_s0_data = '0;
    check("z_handshakes", cycles < 50, 1);
    repeat (6) @(posedge clk);
    #1;
    check("z_beats", z_beats, 2);
    check("z_queue_empty", zexpq.size(), 0);
    check("z_busy_idle", z_busy, 0);
    check("z_m_valid_idle", z_m_valid, 0);

    check("final_q0_empty", expq0.size(), 0);
    check("final_q1_empty", expq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
